// File: rtl/cp0_exc_sched.sv
// CP0 exception/interrupt scheduler at the M/W boundary. It decides which event is taken
// (interrupt, exception, eret, mtc0), holds SR/Cause/EPC and redirects the PC.
module cp0_exc_sched #(
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL  = 32'h0000_3008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic [31:0] causeM,
  input  logic [31:0] pcM,
  input  logic [5:0]  hwint,
  input  logic        eretM,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wd,
  output logic [31:0] cp0_rd,
  output logic        exc_flush,
  output logic        pc_redirect,
  output logic [31:0] npc_target,
  output logic [31:0] epc_out
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NINT = 6;
  localparam int unsigned ECW  = 5;
  localparam int unsigned AW   = 5;

  localparam logic [AW-1:0] ADDR_SR    = AW'(12);
  localparam logic [AW-1:0] ADDR_CAUSE = AW'(13);
  localparam logic [AW-1:0] ADDR_EPC   = AW'(14);
  localparam logic [AW-1:0] ADDR_PRID  = AW'(15);

  // SR.EXL doubles as the FSM state
  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              ie_q, ie_d;
  logic [NINT-1:0]   im_q, im_d;
  logic [NINT-1:0]   ip_q;
  logic              bd_q, bd_d;
  logic [ECW-1:0]    exc_code_q, exc_code_d;
  logic [XLEN-1:0]   epc_q, epc_d;

  logic              exl_c;
  logic              int_take_c;
  logic              exc_take_c;
  logic              take_c;
  logic              eret_c;
  logic              mtc0_c;
  logic [XLEN-1:0]   sr_val_c;
  logic [XLEN-1:0]   cause_val_c;
  logic [XLEN-1:0]   epc_new_c;

  // Event decode and priority: interrupt > exception > eret > mtc0
  always_comb begin
    exl_c       = (state_q == HANDLER);
    int_take_c  = valid_m & ie_q & ~exl_c & (|(ip_q & im_q));
    exc_take_c  = valid_m & (|causeM[30:0]);
    take_c      = int_take_c | exc_take_c;
    eret_c      = valid_m & eretM & ~take_c;
    mtc0_c      = cp0_we & ~take_c & ~eret_c;
    sr_val_c    = {16'b0, im_q, 8'b0, exl_c, ie_q};
    cause_val_c = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
    epc_new_c   = causeM[31] ? (pcM - XLEN'(4)) : pcM;
    epc_new_c   = {epc_new_c[XLEN-1:2], 2'b00};
  end

  // mfc0 read mux; a same-cycle mtc0 is deliberately not forwarded
  always_comb begin
    cp0_rd = '0;
    case (cp0_addr)
      ADDR_SR:    cp0_rd = sr_val_c;
      ADDR_CAUSE: cp0_rd = cause_val_c;
      ADDR_EPC:   cp0_rd = epc_q;
      ADDR_PRID:  cp0_rd = PRID_VAL;
      default:    cp0_rd = '0;
    endcase
  end

  // Next-state and redirect outputs; redirect is suppressed while reset is held
  always_comb begin
    state_d     = state_q;
    ie_d        = ie_q;
    im_d        = im_q;
    bd_d        = bd_q;
    exc_code_d  = exc_code_q;
    epc_d       = epc_q;
    exc_flush   = 1'b0;
    pc_redirect = 1'b0;
    npc_target  = '0;

    if (take_c) begin
      exc_code_d = int_take_c ? ECW'(0) : causeM[6:2];
      bd_d       = causeM[31];
      if (!exl_c) begin
        epc_d = epc_new_c;
      end
      state_d     = HANDLER;
      exc_flush   = reset;
      pc_redirect = reset;
      npc_target  = reset ? EXC_ENTRY : '0;
    end else if (eret_c) begin
      state_d     = RUN;
      exc_flush   = reset;
      pc_redirect = reset;
      npc_target  = reset ? epc_q : '0;
    end else if (mtc0_c) begin
      if (cp0_addr == ADDR_SR) begin
        im_d    = cp0_wd[15:10];
        ie_d    = cp0_wd[0];
        state_d = cp0_wd[1] ? HANDLER : RUN;
      end else if (cp0_addr == ADDR_EPC) begin
        epc_d = {cp0_wd[XLEN-1:2], 2'b00};
      end
    end
  end

  assign epc_out = epc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      ie_q       <= 1'b0;
      im_q       <= '0;
      ip_q       <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      im_q       <= im_d;
      ip_q       <= hwint;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_sched.sv
// Directed bench for cp0_exc_sched: exceptions, delay slot, interrupts, masking, eret,
// mtc0/mfc0 and asynchronous reset mid-handler.
module tb_cp0_exc_sched;

  logic        clk;
  logic        reset;
  logic        valid_m;
  logic [31:0] causeM;
  logic [31:0] pcM;
  logic [5:0]  hwint;
  logic        eretM;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wd;
  logic [31:0] cp0_rd;
  logic        exc_flush;
  logic        pc_redirect;
  logic [31:0] npc_target;
  logic [31:0] epc_out;

  int checks;
  int failures;

  cp0_exc_sched dut (
    .clk         (clk),
    .reset       (reset),
    .valid_m     (valid_m),
    .causeM      (causeM),
    .pcM         (pcM),
    .hwint       (hwint),
    .eretM       (eretM),
    .cp0_we      (cp0_we),
    .cp0_addr    (cp0_addr),
    .cp0_wd      (cp0_wd),
    .cp0_rd      (cp0_rd),
    .exc_flush   (exc_flush),
    .pc_redirect (pc_redirect),
    .npc_target  (npc_target),
    .epc_out     (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    cp0_addr = a;
    #1;
    v = cp0_rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_m = 1'b0;
    causeM  = '0;
    eretM   = 1'b0;
    cp0_we  = 1'b0;
    cp0_wd  = '0;
  endtask

  task automatic chk_redirect(input string tag, input logic f, input logic [31:0] tgt);
    #1;
    chk({tag, "_flush"}, 32'(exc_flush), 32'(f));
    chk({tag, "_redir"}, 32'(pc_redirect), 32'(f));
    chk({tag, "_npc"}, npc_target, tgt);
  endtask

  logic [31:0] v;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    hwint    = '0;
    pcM      = '0;
    cp0_addr = 5'd12;
    idle();

    // Reset state
    #2;
    chk_redirect("rst", 1'b0, 32'h0);
    chk("rst_epc", epc_out, 32'h0);
    rd(5'd12, v); chk("rst_sr", v, 32'h0);
    rd(5'd15, v); chk("rst_prid", v, 32'h0000_3008);
    #2 reset = 1'b1;
    tick();
    rd(5'd13, v); chk("rst_cause", v, 32'h0);
    rd(5'd3, v);  chk("rd_other", v, 32'h0);

    // 1: overflow in RUN
    valid_m = 1'b1; causeM = 32'h0000_0030; pcM = 32'h3008;
    chk_redirect("ovf", 1'b1, 32'h4180);
    tick();
    idle();
    #1;
    chk("ovf_epc", epc_out, 32'h3008);
    rd(5'd13, v); chk("ovf_cause", v, 32'h0000_0030);
    rd(5'd12, v); chk("ovf_sr", v, 32'h0000_0002);

    // 5a: eret back to EPC
    valid_m = 1'b1; eretM = 1'b1;
    chk_redirect("eret", 1'b1, 32'h3008);
    tick();
    idle();
    rd(5'd12, v); chk("eret_sr", v, 32'h0);

    // 2: exception in a delay slot
    valid_m = 1'b1; causeM = 32'h8000_0030; pcM = 32'h3010;
    chk_redirect("bd", 1'b1, 32'h4180);
    tick();
    idle();
    #1;
    chk("bd_epc", epc_out, 32'h300C);
    rd(5'd13, v); chk("bd_cause", v, 32'h8000_0030);
    valid_m = 1'b1; eretM = 1'b1;
    chk_redirect("bd_eret", 1'b1, 32'h300C);
    tick();
    idle();

    // 3: interrupt, registered hwint gives one cycle of delay
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wd = 32'h0000_0401;
    #1;
    chk("mtc0_noforward", cp0_rd, 32'h0);
    tick();
    idle();
    rd(5'd12, v); chk("mtc0_sr", v, 32'h0000_0401);
    hwint = 6'b000001; valid_m = 1'b1; pcM = 32'h3020;
    chk_redirect("int_early", 1'b0, 32'h0);
    tick();
    valid_m = 1'b0;
    chk_redirect("int_bubble", 1'b0, 32'h0);
    valid_m = 1'b1;
    chk_redirect("int_take", 1'b1, 32'h4180);
    tick();
    idle();
    #1;
    chk("int_epc", epc_out, 32'h3020);
    rd(5'd13, v); chk("int_cause", v, 32'h0000_0400);
    rd(5'd12, v); chk("int_sr", v, 32'h0000_0403);

    // 4: interrupts masked in HANDLER; nested exception keeps EPC
    valid_m = 1'b1; pcM = 32'h3040;
    chk_redirect("nest_mask", 1'b0, 32'h0);
    causeM = 32'h0000_0030;
    chk_redirect("nest_ovf", 1'b1, 32'h4180);
    tick();
    idle();
    #1;
    chk("nest_epc", epc_out, 32'h3020);
    rd(5'd13, v); chk("nest_cause", v, 32'h0000_0430);

    // 5b: eret out of HANDLER, then eret colliding with a pending interrupt
    valid_m = 1'b1; eretM = 1'b1;
    chk_redirect("eret2", 1'b1, 32'h3020);
    tick();
    idle();
    rd(5'd12, v); chk("eret2_sr", v, 32'h0000_0401);
    valid_m = 1'b1; eretM = 1'b1; pcM = 32'h3020;
    chk_redirect("eret_vs_int", 1'b1, 32'h4180);
    tick();
    idle();
    #1;
    chk("eret_vs_int_epc", epc_out, 32'h3020);
    rd(5'd12, v); chk("eret_vs_int_sr", v, 32'h0000_0403);
    rd(5'd13, v); chk("eret_vs_int_cause", v, 32'h0000_0400);
    valid_m = 1'b1; eretM = 1'b1;
    chk_redirect("eret3", 1'b1, 32'h3020);
    tick();
    idle();

    // 3b: interrupt masked by IM=0
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wd = 32'h0000_0001;
    tick();
    idle();
    valid_m = 1'b1; pcM = 32'h3030;
    chk_redirect("im_masked", 1'b0, 32'h0);
    tick();
    idle();
    hwint = '0;

    // 6: asynchronous reset in the middle of a handler
    valid_m = 1'b1; causeM = 32'h0000_0030; pcM = 32'h3050;
    tick();
    #1;
    chk("pre_rst_epc", epc_out, 32'h3050);
    reset = 1'b0;
    chk_redirect("mid_rst", 1'b0, 32'h0);
    chk("mid_rst_epc", epc_out, 32'h0);
    rd(5'd12, v); chk("mid_rst_sr", v, 32'h0);
    rd(5'd13, v); chk("mid_rst_cause", v, 32'h0);
    idle();
    tick();
    reset = 1'b1;
    tick();
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wd = 32'h3007;
    tick();
    idle();
    rd(5'd14, v); chk("mtc0_epc", v, 32'h3004);
    chk("mtc0_epc_out", epc_out, 32'h3004);
    cp0_we = 1'b1; cp0_addr = 5'd13; cp0_wd = 32'hFFFF_FFFF;
    tick();
    idle();
    rd(5'd13, v); chk("cause_ro", v, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
